// File: rtl/lbp_window_calc.sv
// LBP window calculator: keeps a 3x3 gray window, refills only the missing pixels per step,
// and writes one 8-bit LBP code per centre. Optional read counter behind LBP_RDCNT_EN.
module lbp_window_calc #(
  parameter int AW_HALF = 7,
  parameter int DW      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init,
  input  logic [1:0]             move,
  input  logic [2*AW_HALF-1:0]   center_addr,
  output logic                   gray_req,
  output logic [2*AW_HALF-1:0]   gray_addr,
  input  logic [DW-1:0]          gray_data,
  output logic                   busy,
  output logic                   lbp_valid,
  output logic [2*AW_HALF-1:0]   lbp_addr,
  output logic [DW-1:0]          lbp_data
`ifdef LBP_RDCNT_EN
  ,
  output logic [15:0]            rd_cnt
`endif
);

  localparam int AW = 2*AW_HALF;
  localparam logic [AW_HALF-1:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_CALC, S_WRITE, S_BORDER} state_t;
  typedef enum logic [1:0] {M_RIGHT = 2'b00, M_LEFT = 2'b01, M_DOWN = 2'b10, M_INIT = 2'b11} mode_t;

  state_t               state_q, state_d;
  mode_t                mode_q, mode_in, f_mode;
  logic [AW_HALF-1:0]   row_q, col_q, r_in, c_in, f_r, f_c;
  logic [3:0]           k_q, f_k, f_slot, last_k, req_slot_q, pend_slot_q;
  logic                 req_q, pend_q, lv_q;
  logic [AW-1:0]        gaddr_q, laddr_q, f_addr;
  logic [DW-1:0]        ldata_q;
  logic [8:0][DW-1:0]   win_q;
  logic [7:0]           code_c;
  logic                 at_border, shift_en;

  // Window slot filled by the k-th fetch of a step (slots in raster order w0..w8)
  function automatic logic [3:0] slot_of(input mode_t m, input logic [3:0] k);
    case (m)
      M_RIGHT: slot_of = 4'd2 + 4'd3 * k;
      M_LEFT:  slot_of = 4'd3 * k;
      M_DOWN:  slot_of = 4'd6 + k;
      default: slot_of = k;
    endcase
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [3:0] s, input logic [AW_HALF-1:0] r,
                                            input logic [AW_HALF-1:0] c);
    logic [AW_HALF-1:0] ra, ca;
    ra = (s < 4'd3) ? r - ONE : (s < 4'd6) ? r : r + ONE;
    case (s)
      4'd0, 4'd3, 4'd6: ca = c - ONE;
      4'd1, 4'd4, 4'd7: ca = c;
      default:          ca = c + ONE;
    endcase
    addr_of = {ra, ca};
  endfunction

  assign r_in      = center_addr[AW-1:AW_HALF];
  assign c_in      = center_addr[AW_HALF-1:0];
  assign at_border = (r_in == '0) || (r_in == '1) || (c_in == '0) || (c_in == '1);
  assign mode_in   = (init || move == 2'b11) ? M_INIT : mode_t'(move);
  assign last_k    = (mode_q == M_INIT) ? 4'd8 : 4'd2;
  assign shift_en  = (state_q == S_IDLE) && start && !at_border;

  // Address generator: first fetch comes from the request inputs, later ones from latched state
  always_comb begin
    f_mode = mode_q;
    f_k    = k_q + 4'd1;
    f_r    = row_q;
    f_c    = col_q;
    if (state_q == S_IDLE) begin
      f_mode = mode_in;
      f_k    = 4'd0;
      f_r    = r_in;
      f_c    = c_in;
    end
    f_slot = slot_of(f_mode, f_k);
    f_addr = addr_of(f_slot, f_r, f_c);
  end

  always_comb begin
    code_c    = '0;
    code_c[0] = win_q[0] >= win_q[4];
    code_c[1] = win_q[1] >= win_q[4];
    code_c[2] = win_q[2] >= win_q[4];
    code_c[3] = win_q[3] >= win_q[4];
    code_c[4] = win_q[5] >= win_q[4];
    code_c[5] = win_q[6] >= win_q[4];
    code_c[6] = win_q[7] >= win_q[4];
    code_c[7] = win_q[8] >= win_q[4];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = at_border ? S_BORDER : S_FETCH;
      S_FETCH:  if (k_q == last_k) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_CALC;
      S_CALC:   state_d = S_WRITE;
      S_WRITE:  state_d = S_IDLE;
      S_BORDER: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= M_INIT;
      k_q         <= '0;
      req_q       <= 1'b0;
      gaddr_q     <= '0;
      req_slot_q  <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      lv_q        <= 1'b0;
      laddr_q     <= '0;
      ldata_q     <= '0;
    end else begin
      // Read data arrives one cycle after its strobe; remember where it goes
      pend_q      <= req_q;
      pend_slot_q <= req_slot_q;
      lv_q        <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          row_q  <= r_in;
          col_q  <= c_in;
          mode_q <= mode_in;
          if (at_border) begin
            lv_q    <= 1'b1;
            laddr_q <= center_addr;
            ldata_q <= '0;
          end else begin
            req_q      <= 1'b1;
            gaddr_q    <= f_addr;
            req_slot_q <= f_slot;
            k_q        <= '0;
          end
        end
        S_FETCH: begin
          if (k_q == last_k) begin
            req_q <= 1'b0;
          end else begin
            k_q        <= k_q + 4'd1;
            gaddr_q    <= f_addr;
            req_slot_q <= f_slot;
          end
        end
        S_CALC: begin
          lv_q    <= 1'b1;
          laddr_q <= {row_q, col_q};
          ldata_q <= DW'(code_c);
        end
        default: ;
      endcase
    end
  end

  // Window: shift on step entry, then fill slots as read data returns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
    end else if (shift_en) begin
      case (mode_in)
        M_RIGHT: begin
          win_q[0] <= win_q[1]; win_q[1] <= win_q[2];
          win_q[3] <= win_q[4]; win_q[4] <= win_q[5];
          win_q[6] <= win_q[7]; win_q[7] <= win_q[8];
        end
        M_LEFT: begin
          win_q[2] <= win_q[1]; win_q[1] <= win_q[0];
          win_q[5] <= win_q[4]; win_q[4] <= win_q[3];
          win_q[8] <= win_q[7]; win_q[7] <= win_q[6];
        end
        M_DOWN: begin
          win_q[0] <= win_q[3]; win_q[1] <= win_q[4]; win_q[2] <= win_q[5];
          win_q[3] <= win_q[6]; win_q[4] <= win_q[7]; win_q[5] <= win_q[8];
        end
        default: ;
      endcase
    end else if (pend_q) begin
      win_q[pend_slot_q] <= gray_data;
    end
  end

`ifdef LBP_RDCNT_EN
  logic [15:0] rd_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            rd_cnt_q <= '0;
    else if (req_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
  end
  assign rd_cnt = rd_cnt_q;
`endif

  assign gray_req  = req_q;
  assign gray_addr = gaddr_q;
  assign busy      = (state_q != S_IDLE);
  assign lbp_valid = lv_q;
  assign lbp_addr  = laddr_q;
  assign lbp_data  = ldata_q;

endmodule

// File: tb/tb_lbp_window_calc.sv
// Bench for lbp_window_calc: directed steps plus random walks checked against a 3x3 window model.
module tb_lbp_window_calc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        init = 1'b0;
  logic [1:0]  move = 2'b00;
  logic [13:0] center_addr = '0;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data = '0;
  logic        busy, lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
`ifdef LBP_RDCNT_EN
  logic [15:0] rd_cnt;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [16384];
  logic [7:0] mw [3][3];
  int         cur_r, cur_c;

  lbp_window_calc #(.AW_HALF(7), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .init(init), .move(move),
    .center_addr(center_addr), .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_data(gray_data), .busy(busy), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data)
`ifdef LBP_RDCNT_EN
    , .rd_cnt(rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Gray memory: data for the address strobed in one cycle is presented in the next
  always @(posedge clk) gray_data <= mem[gray_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] pa(input int r, input int c);
    return 14'(r * 128 + c);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mw[i][j] = '0;
  endtask

  // One step: model predicts reads, code and timing, then every cycle is compared
  task automatic step(input bit i_init, input logic [1:0] i_move, input int r, input int c,
                      input bit poke);
    int          fi[$], fj[$];
    logic [13:0] ea[$];
    logic [7:0]  code;
    int          n, v, b;
    bit          border, ereq;
`ifdef LBP_RDCNT_EN
    logic [15:0] cnt0;
    cnt0 = rd_cnt;
`endif
    code   = '0;
    n      = 0;
    border = (r == 0 || r == 127 || c == 0 || c == 127);
    if (!border) begin
      if (i_init || i_move == 2'b11) begin
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
          fi.push_back(i); fj.push_back(j);
        end
      end else if (i_move == 2'b00) begin
        for (int i = 0; i < 3; i++) begin
          mw[i][0] = mw[i][1]; mw[i][1] = mw[i][2]; fi.push_back(i); fj.push_back(2);
        end
      end else if (i_move == 2'b01) begin
        for (int i = 0; i < 3; i++) begin
          mw[i][2] = mw[i][1]; mw[i][1] = mw[i][0]; fi.push_back(i); fj.push_back(0);
        end
      end else begin
        for (int j = 0; j < 3; j++) begin
          mw[0][j] = mw[1][j]; mw[1][j] = mw[2][j]; fi.push_back(2); fj.push_back(j);
        end
      end
      n = fi.size();
      for (int q = 0; q < n; q++) begin
        ea.push_back(pa(r + fi[q] - 1, c + fj[q] - 1));
        mw[fi[q]][fj[q]] = mem[pa(r + fi[q] - 1, c + fj[q] - 1)];
      end
      b = 0;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
        if (!(i == 1 && j == 1)) begin
          code[b] = (mw[i][j] >= mw[1][1]);
          b++;
        end
      v = n + 3;
    end else begin
      v = 1;
    end

    @(negedge clk);
    chk("busy_c0", busy, 1'b0);
    start = 1'b1; init = i_init; move = i_move; center_addr = {7'(r), 7'(c)};
    for (int cyc = 1; cyc <= v + 2; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      ereq = (cyc <= n);
      chk("gray_req", gray_req, ereq);
      if (ereq) chk("gray_addr", gray_addr, ea[cyc-1]);
      chk("lbp_valid", lbp_valid, cyc == v);
      chk("busy", busy, cyc <= v);
      if (cyc >= v) begin
        chk("lbp_addr", lbp_addr, {7'(r), 7'(c)});
        chk("lbp_data", lbp_data, code);
      end
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 4) start = 1'b0;
    end
`ifdef LBP_RDCNT_EN
    chk("rd_cnt", rd_cnt, cnt0 + 16'(n));
`endif
    if (!border) begin cur_r = r; cur_c = c; end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   gray_req,  1'b0);
    chk({tag, "_gaddr"}, gray_addr, 14'h0);
    chk({tag, "_busy"},  busy,      1'b0);
    chk({tag, "_valid"}, lbp_valid, 1'b0);
    chk({tag, "_laddr"}, lbp_addr,  14'h0);
    chk({tag, "_ldata"}, lbp_data,  8'h0);
`ifdef LBP_RDCNT_EN
    chk({tag, "_rdcnt"}, rd_cnt, 16'h0);
`endif
  endtask

  initial begin
    int m, kind, nr, nc;
    bit pk;
    for (int r = 0; r < 128; r++) for (int c = 0; c < 128; c++) mem[pa(r, c)] = 8'(r * 128 + c);
    clear_model();
    cur_r = 1; cur_c = 1;

    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;

    // Move on the zeroed window straight after reset
    step(1'b0, 2'b10, 5, 5, 1'b0);

    // Power-on-style sequence: init then right move
    reset = 1'b0; clear_model(); @(negedge clk); reset = 1'b1;
    step(1'b1, 2'b00, 1, 1, 1'b0);
    step(1'b0, 2'b00, 1, 2, 1'b0);

    // Flat field with a bright centre, then a dark centre
    for (int a = 0; a < 16384; a++) mem[a] = 8'd50;
    mem[pa(2, 126)] = 8'd60;
    mem[pa(2, 125)] = 8'd60;
    step(1'b1, 2'b00, 1, 126, 1'b0);
    step(1'b0, 2'b10, 2, 126, 1'b0);
    step(1'b0, 2'b01, 2, 125, 1'b0);
    mem[pa(2, 126)] = 8'd50;
    mem[pa(2, 125)] = 8'd40;
    step(1'b1, 2'b00, 2, 125, 1'b0);

    // Border centre, then a move with a start pulse while busy
    step(1'b0, 2'b00, 0, 127, 1'b0);
    step(1'b0, 2'b00, 2, 126, 1'b1);

    // Reset in the middle of an init fetch
    @(negedge clk);
    start = 1'b1; init = 1'b1; move = 2'b00; center_addr = pa(5, 5);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk); @(negedge clk);
    check_reset_vals("hold");
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("post_rst_valid", lbp_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
    clear_model();
    for (int r = 0; r < 128; r++) for (int c = 0; c < 128; c++) mem[pa(r, c)] = 8'(r * 128 + c);
    step(1'b1, 2'b00, 1, 1, 1'b0);
    step(1'b0, 2'b00, 1, 2, 1'b0);

    // Random walk over random contents; high values and ties are deliberately common
    for (int a = 0; a < 16384; a++)
      mem[a] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'(200 + $urandom_range(0, 3));
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 9);
      pk   = ($urandom_range(0, 3) == 0);
      if (kind == 0) begin
        nr = $urandom_range(0, 127); nc = $urandom_range(0, 127);
        case ($urandom_range(0, 3))
          0: nr = 0;
          1: nr = 127;
          2: nc = 0;
          default: nc = 127;
        endcase
        step(1'b0, 2'b00, nr, nc, 1'b0);
      end else if (kind == 1) begin
        step(1'b1, 2'($urandom_range(0, 3)), $urandom_range(1, 126), $urandom_range(1, 126), pk);
      end else if (kind == 2) begin
        step(1'b0, 2'b11, $urandom_range(1, 126), $urandom_range(1, 126), pk);
      end else begin
        m  = $urandom_range(0, 2);
        nr = cur_r + ((m == 2) ? 1 : 0);
        nc = cur_c + ((m == 0) ? 1 : (m == 1) ? -1 : 0);
        if (nr < 1 || nr > 126 || nc < 1 || nc > 126) begin
          nr = $urandom_range(1, 126); nc = $urandom_range(1, 126);
        end
        step(1'b0, 2'(m), nr, nc, pk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
